// File: rtl/hamsi_host_driver.sv
// hamsi_host_driver: host-side initiator for the Hamsi core interface.
// Streams 32-bit words as halfword loads, finalises, fetches the digest.
module hamsi_host_driver #(
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             msg_valid,
    input  logic [31:0]      msg_data,
    input  logic             msg_last,
    output logic             msg_ready,
    output logic             init,
    output logic             load,
    output logic             fetch,
    output logic [15:0]      idata,
    output logic             EOM,
    input  logic             ack,
    input  logic [15:0]      odata,
    input  logic             busy,
    output logic [255:0]     digest,
    output logic             digest_valid,
    output logic [CNT_W-1:0] words_sent,
    output logic             err
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_WAIT_BUSY0, S_WORD,
        S_LOAD_HI, S_ACK_HI, S_GAP_HI,
        S_LOAD_LO, S_ACK_LO, S_GAP_LO,
        S_FINAL, S_FETCH, S_FACK, S_FWAIT,
        S_DONE, S_ERR
    } state_t;

    state_t state_q, state_d;
    logic [31:0] word_q, word_d;
    logic last_q, last_d;
    logic phase_q, phase_d;
    logic [3:0] hw_q, hw_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [15:0] idata_q, idata_d;
    logic [255:0] digest_q, digest_d;
    logic [CNT_W-1:0] words_sent_q, words_sent_d;
    logic msg_ready_q, msg_ready_d;
    logic init_q, init_d;
    logic load_q, load_d;
    logic fetch_q, fetch_d;
    logic eom_q, eom_d;
    logic dv_q, dv_d;
    logic err_q, err_d;
    logic timeout;

    assign timeout = (wait_q == TW'(ACK_TIMEOUT - 1));

    // Next-state, datapath updates and registered-output decode
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        last_d       = last_q;
        phase_d      = phase_q;
        hw_d         = hw_q;
        wait_d       = wait_q;
        idata_d      = idata_q;
        digest_d     = digest_q;
        words_sent_d = words_sent_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_INIT;
                    words_sent_d = '0;
                end
            end
            S_INIT: state_d = S_WAIT_BUSY0;
            S_WAIT_BUSY0: begin
                if (!busy) state_d = S_WORD;
            end
            S_WORD: begin
                if (msg_valid) begin
                    word_d       = msg_data;
                    last_d       = msg_last;
                    words_sent_d = words_sent_q + 1'b1;
                    idata_d      = msg_data[31:16];
                    state_d      = S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                wait_d  = '0;
                state_d = S_ACK_HI;
            end
            S_ACK_HI: begin
                if (ack) state_d = S_GAP_HI;
                else if (timeout) state_d = S_ERR;
                else wait_d = wait_q + TW'(1);
            end
            S_GAP_HI: begin
                if (!busy) begin
                    idata_d = word_q[15:0];
                    state_d = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                wait_d  = '0;
                state_d = S_ACK_LO;
            end
            S_ACK_LO: begin
                if (ack) state_d = S_GAP_LO;
                else if (timeout) state_d = S_ERR;
                else wait_d = wait_q + TW'(1);
            end
            S_GAP_LO: begin
                if (!busy) begin
                    if (last_q) begin
                        wait_d  = '0;
                        phase_d = 1'b0;
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_WORD;
                    end
                end
            end
            S_FINAL: begin
                if (!phase_q) begin
                    if (busy) phase_d = 1'b1;
                    else if (timeout) state_d = S_ERR;
                    else wait_d = wait_q + TW'(1);
                end else if (!busy) begin
                    hw_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                wait_d  = '0;
                state_d = S_FACK;
            end
            S_FACK: begin
                if (ack) begin
                    digest_d = {digest_q[239:0], odata};
                    hw_d     = hw_q + 4'd1;
                    state_d  = (hw_q == 4'd15) ? S_DONE : S_FWAIT;
                end else if (timeout) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            S_FWAIT: begin
                if (!busy && !ack) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERR) idata_d = '0;
        msg_ready_d = (state_d == S_WORD);
        init_d      = (state_d == S_INIT);
        load_d      = (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO);
        fetch_d     = (state_d == S_FETCH);
        eom_d       = (state_d == S_FINAL);
        dv_d        = (state_d == S_DONE);
        err_d       = (state_d == S_ERR);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            last_q       <= 1'b0;
            phase_q      <= 1'b0;
            hw_q         <= '0;
            wait_q       <= '0;
            idata_q      <= '0;
            digest_q     <= '0;
            words_sent_q <= '0;
            msg_ready_q  <= 1'b0;
            init_q       <= 1'b0;
            load_q       <= 1'b0;
            fetch_q      <= 1'b0;
            eom_q        <= 1'b0;
            dv_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            last_q       <= last_d;
            phase_q      <= phase_d;
            hw_q         <= hw_d;
            wait_q       <= wait_d;
            idata_q      <= idata_d;
            digest_q     <= digest_d;
            words_sent_q <= words_sent_d;
            msg_ready_q  <= msg_ready_d;
            init_q       <= init_d;
            load_q       <= load_d;
            fetch_q      <= fetch_d;
            eom_q        <= eom_d;
            dv_q         <= dv_d;
            err_q        <= err_d;
        end
    end

    assign msg_ready    = msg_ready_q;
    assign init         = init_q;
    assign load         = load_q;
    assign fetch        = fetch_q;
    assign idata        = idata_q;
    assign EOM          = eom_q;
    assign digest       = digest_q;
    assign digest_valid = dv_q;
    assign words_sent   = words_sent_q;
    assign err          = err_q;
endmodule

// File: tb/tb_hamsi_host_driver.sv
// tb_hamsi_host_driver: randomized bench with a behavioural core model
// and a transaction-level scoreboard for hamsi_host_driver.
module tb_hamsi_host_driver;
    localparam int CW = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic msg_valid = 1'b0;
    logic [31:0] msg_data = '0;
    logic msg_last = 1'b0;
    logic ack = 1'b0;
    logic busy = 1'b0;
    logic [15:0] odata = '0;
    logic msg_ready, init, load, fetch, EOM, digest_valid, err;
    logic [15:0] idata;
    logic [255:0] digest;
    logic [CW-1:0] words_sent;

    always #5 clk = ~clk;

    hamsi_host_driver #(.ACK_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last),
        .msg_ready(msg_ready), .init(init), .load(load), .fetch(fetch),
        .idata(idata), .EOM(EOM), .ack(ack), .odata(odata), .busy(busy),
        .digest(digest), .digest_valid(digest_valid),
        .words_sent(words_sent), .err(err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // core model controls
    int ack_dly_max = 3;
    int withhold_at = -1;
    bit odata_count = 1'b0;
    bit stray_en = 1'b0;
    int core_loads = 0;
    int fidx = 0;
    logic [15:0] given[$];
    int c_pend = 0, c_tail = 0, c_est = 0, c_ecnt = 0;
    bit c_pk = 1'b0;

    // behavioural Hamsi core: busy/ack per pulse, busy pulse on EOM
    initial begin
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (!rst_n) begin
                busy = 1'b0; c_pend = 0; c_tail = 0; c_est = 0;
            end else begin
                if (load || fetch) begin
                    if (load) core_loads++;
                    if (!(load && core_loads == withhold_at)) begin
                        busy = 1'b1;
                        c_pend = 1 + int'($urandom % ack_dly_max);
                        c_tail = int'($urandom % 3);
                        c_pk = fetch;
                        if (stray_en && ($urandom % 2 == 1)) ack = 1'b1;
                    end
                end else if (c_pend > 0) begin
                    c_pend--;
                    if (c_pend == 0) begin
                        ack = 1'b1;
                        if (c_pk) begin
                            odata = odata_count ? 16'(fidx) : 16'($urandom);
                            fidx++;
                            given.push_back(odata);
                        end
                        if (c_tail == 0) busy = 1'b0;
                    end
                end else if (c_tail > 0) begin
                    c_tail--;
                    if (c_tail == 0) busy = 1'b0;
                end
                if (!EOM) c_est = 0;
                else begin
                    if (c_est == 0) begin
                        c_ecnt = int'($urandom % 3); c_est = 1;
                    end
                    if (c_est == 1) begin
                        if (c_ecnt == 0) begin
                            busy = 1'b1; c_ecnt = 2 + int'($urandom % 4); c_est = 2;
                        end else c_ecnt--;
                    end else if (c_est == 2) begin
                        if (c_ecnt == 0) begin
                            busy = 1'b0; c_est = 3;
                        end else c_ecnt--;
                    end
                end
            end
        end
    end

    // scoreboard state
    int n_init = 0, n_load = 0, n_fetch = 0;
    int unsigned exp_ws = 0;
    logic [15:0] exp_hw[$];
    logic [15:0] load_vals[$];
    logic [31:0] msg_words[$];
    logic p_ready, p_load, p_fetch, p_eom, p_dv, p_err, p_init;
    logic seen, in_load;
    logic [15:0] cur_idata;
    logic [255:0] e_dig;

    // per-cycle compare against the transaction model
    initial begin
        {p_ready, p_load, p_fetch, p_eom, p_dv, p_err, p_init} = '0;
        seen = 1'b0; in_load = 1'b0; cur_idata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                {p_ready, p_load, p_fetch, p_eom, p_dv, p_err, p_init} = '0;
                seen = 1'b0; in_load = 1'b0; exp_ws = 0;
            end else begin
                chk("onehot_pulse", $countones({init, load, fetch}) <= 1, 1);
                if (load) chk("load_busy_low", busy, 0);
                if (msg_ready) begin
                    chk("ready_only_word", {load, fetch, EOM, init}, 0);
                    chk("ready_not_busy", busy, 0);
                end
                if (p_ready && msg_valid) begin
                    exp_ws = (exp_ws + 1) % (1 << CW);
                    chk("words_sent", words_sent, exp_ws);
                    chk("ready_drop", msg_ready, 0);
                    exp_hw.push_back(msg_data[31:16]);
                    exp_hw.push_back(msg_data[15:0]);
                end
                if (init && !p_init) begin
                    n_init++; exp_ws = 0; in_load = 1'b0;
                    chk("init_ws", words_sent, 0);
                    chk("init_dv", digest_valid, 0);
                    chk("init_err", err, 0);
                end
                if (err && !p_err) begin
                    in_load = 1'b0;
                    chk("err_core_quiet", {init, load, fetch, EOM}, 0);
                    chk("err_idata", idata, 0);
                end
                if (load && !p_load) begin
                    n_load++;
                    load_vals.push_back(idata);
                    chk("load_pending", exp_hw.size() > 0, 1);
                    if (exp_hw.size() > 0) chk("load_idata", idata, exp_hw.pop_front());
                    in_load = 1'b1; cur_idata = idata;
                end else if (in_load) begin
                    chk("idata_hold", idata, cur_idata);
                    if (ack && !p_load) in_load = 1'b0;
                end
                if (fetch && !p_fetch) n_fetch++;
                if (p_eom && !EOM) chk("eom_after_busy", seen, 1);
                if (seen && !busy) begin
                    chk("eom_drop", EOM, 0);
                    chk("fetch_after_eom", fetch, 1);
                    seen = 1'b0;
                end else if (p_eom && busy) seen = 1'b1;
                if (digest_valid && !p_dv) begin
                    chk("digest_acks", given.size(), 16);
                    if (given.size() >= 16) begin
                        e_dig = '0;
                        for (int k = 0; k < 16; k++)
                            e_dig[255 - 16*k -: 16] = given[given.size() - 16 + k];
                        chk("digest", digest, e_dig);
                    end
                end
                p_ready = msg_ready; p_load = load; p_fetch = fetch;
                p_eom = EOM; p_dv = digest_valid; p_err = err; p_init = init;
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_words(input int gap, input bit hold, input bit noise);
        int t;
        for (int i = 0; i < msg_words.size(); i++) begin
            if (!hold) begin
                msg_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            msg_valid = 1'b1;
            msg_data = msg_words[i];
            msg_last = (i == msg_words.size() - 1);
            t = 0;
            while (!msg_ready && t < 2000) begin
                @(negedge clk);
                if (noise) start = ($urandom % 3 == 0);
                t++;
            end
            chk("ready_wait", t < 2000, 1);
            @(negedge clk);
            start = 1'b0;
        end
        msg_valid = 1'b0;
        msg_last = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!digest_valid && !err && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", t < 3000, 1);
    endtask

    task automatic run_msg(input string tag, input int gap, input bit hold,
                           input bit noise);
        int b_init, b_load, b_fetch;
        b_init = n_init; b_load = n_load; b_fetch = n_fetch;
        given.delete(); load_vals.delete(); fidx = 0;
        do_start();
        chk({tag, "_err_clr"}, err, 0);
        chk({tag, "_dv_clr"}, digest_valid, 0);
        send_words(gap, hold, noise);
        wait_done();
        chk({tag, "_dv"}, digest_valid, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_inits"}, n_init - b_init, 1);
        chk({tag, "_loads"}, n_load - b_load, 2 * msg_words.size());
        chk({tag, "_fetches"}, n_fetch - b_fetch, 16);
        chk({tag, "_ws"}, words_sent, msg_words.size() % (1 << CW));
        chk({tag, "_hw_left"}, exp_hw.size(), 0);
        chk({tag, "_eom"}, EOM, 0);
    endtask

    int nw, b_ld, t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", msg_ready, 0);
        chk("rst_pulses", {init, load, fetch}, 0);
        chk("rst_eom", EOM, 0);
        chk("rst_idata", idata, 0);
        chk("rst_digest", digest, 0);
        chk("rst_dv", digest_valid, 0);
        chk("rst_ws", words_sent, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        msg_words = '{32'hDEADBEEF};
        ack_dly_max = 2;
        run_msg("t1", 0, 0, 0);
        chk("t1_hi", load_vals[0], 16'hDEAD);
        chk("t1_lo", load_vals[1], 16'hBEEF);
        chk("t1_ws", words_sent, 1);

        odata_count = 1'b1;
        msg_words = '{32'h01234567};
        run_msg("t2", 0, 0, 0);
        chk("t2_digest", digest,
            256'h0000000100020003000400050006000700080009000A000B000C000D000E000F);
        odata_count = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_frozen", digest[15:0], 16'h000F);

        ack_dly_max = 3;
        msg_words = '{32'h11112222, 32'h33334444, 32'h55556666};
        run_msg("t3", 5, 0, 0);
        chk("t3_ws", words_sent, 3);

        msg_words = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
        run_msg("t4", 0, 1, 0);

        msg_words.delete();
        for (int i = 0; i < 17; i++) msg_words.push_back($urandom);
        run_msg("t5", 0, 1, 0);
        chk("t5_wrap", words_sent, 1);

        for (int m = 0; m < 6; m++) begin
            nw = 1 + int'($urandom % 5);
            msg_words.delete();
            for (int i = 0; i < nw; i++) msg_words.push_back($urandom);
            ack_dly_max = 1 + int'($urandom % 4);
            stray_en = 1'b1;
            run_msg("rand", int'($urandom % 4), 1'($urandom % 2), 1'b1);
        end
        stray_en = 1'b0;

        withhold_at = core_loads + 2;
        b_ld = n_load;
        msg_words = '{32'h12345678};
        do_start();
        send_words(0, 0, 0);
        t = 0;
        while (!(load && n_load == b_ld + 2) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("to_second_load", t < 200, 1);
        repeat (TO) @(negedge clk);
        chk("to_err_early", err, 0);
        @(negedge clk);
        chk("to_err", err, 1);
        chk("to_quiet", {init, load, fetch, EOM}, 0);
        chk("to_idata", idata, 0);
        repeat (5) @(negedge clk);
        chk("to_sticky", err, 1);
        withhold_at = -1;
        msg_words = '{32'hCAFEF00D, 32'h0BADBEEF};
        run_msg("t7", 1, 0, 0);

        b_ld = n_load;
        msg_words = '{32'h5A5AA5A5};
        do_start();
        send_words(0, 0, 0);
        t = 0;
        while (!(load && n_load == b_ld + 2) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_reach", t < 200, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_load", load, 0);
        chk("rst_mid_eom", EOM, 0);
        chk("rst_mid_idata", idata, 0);
        chk("rst_mid_ready", msg_ready, 0);
        @(posedge clk); #2;
        chk("rst_mid_load2", {init, load, fetch}, 0);
        chk("rst_mid_ws", words_sent, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_hw.delete();
        @(negedge clk);
        msg_words = '{32'h76543210};
        run_msg("t9", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
